// File: rtl/vproc_mem_monitor.sv
// Multi-channel memory-bus monitor: tracks outstanding requests per channel, detects the
// program-end request and bus/protocol faults, and counts cycles spent running.
module vproc_mem_monitor #(
  parameter int unsigned       NCH      = 2,
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] END_ADDR = '0,
  parameter int unsigned       MAX_OUT  = 4,
  parameter int unsigned       TIMEOUT  = 1024,
  parameter int unsigned       CNT_W    = 32
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     clear_i,
  input  logic [NCH-1:0]                           mem_req_i,
  input  logic [NCH*ADDR_W-1:0]                    mem_addr_i,
  input  logic [NCH-1:0]                           mem_rvalid_i,
  input  logic [NCH-1:0]                           mem_err_i,
  output logic [1:0]                               state_o,
  output logic                                     done_o,
  output logic                                     fault_o,
  output logic [3:0]                               fault_cause_o,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] fault_ch_o,
  output logic [ADDR_W-1:0]                        fault_addr_o,
  output logic [CNT_W-1:0]                         cycle_cnt_o
);

  localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned OC_W = $clog2(MAX_OUT + 1);
  localparam int unsigned TC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;
  localparam logic [1:0] StFault = 2'd3;

  logic [1:0]                  state_q, state_d;
  logic [NCH-1:0][OC_W-1:0]    oc_q, oc_d;
  logic [NCH-1:0][TC_W-1:0]    tc_q, tc_d;
  logic [NCH-1:0][ADDR_W-1:0]  la_q, la_d;
  logic [3:0]                  cause_q, cause_d;
  logic [CH_W-1:0]             ch_q, ch_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;

  logic [NCH-1:0][3:0]         cause_c;
  logic [NCH-1:0]              end_c;
  logic                        active;
  logic                        found;

  // Per-channel fault causes and end detection, from the current-cycle inputs.
  always_comb begin
    cause_c = '0;
    end_c   = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      cause_c[c][0] = mem_rvalid_i[c] & mem_err_i[c];
      cause_c[c][1] = mem_rvalid_i[c] & (oc_q[c] == '0);
      cause_c[c][2] = mem_req_i[c] & ~mem_rvalid_i[c] & (oc_q[c] == OC_W'(MAX_OUT));
      cause_c[c][3] = ~mem_rvalid_i[c] & (oc_q[c] != '0) & (tc_q[c] == TC_W'(TIMEOUT - 1));
      end_c[c]      = mem_req_i[c] & (mem_addr_i[c*ADDR_W +: ADDR_W] == END_ADDR);
    end
  end

  assign active = (state_q == StIdle) || (state_q == StRun);

  always_comb begin
    state_d = state_q;
    oc_d    = oc_q;
    tc_d    = tc_q;
    la_d    = la_q;
    cause_d = cause_q;
    ch_d    = ch_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    found   = 1'b0;

    if (clear_i) begin
      state_d = StIdle;
      oc_d    = '0;
      tc_d    = '0;
      la_d    = '0;
      cause_d = '0;
      ch_d    = '0;
      addr_d  = '0;
      cnt_d   = '0;
    end else if (active) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        // Saturating guards keep the counters in range on the cycle a fault is taken.
        case ({mem_req_i[c], mem_rvalid_i[c]})
          2'b10: if (oc_q[c] != OC_W'(MAX_OUT)) oc_d[c] = oc_q[c] + 1'b1;
          2'b01: if (oc_q[c] != '0) oc_d[c] = oc_q[c] - 1'b1;
          default: ;
        endcase
        if ((oc_q[c] == '0) || mem_rvalid_i[c]) begin
          tc_d[c] = '0;
        end else if (tc_q[c] != TC_W'(TIMEOUT - 1)) begin
          tc_d[c] = tc_q[c] + 1'b1;
        end
        if (mem_req_i[c]) la_d[c] = mem_addr_i[c*ADDR_W +: ADDR_W];
      end

      if ((state_q == StRun) && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;

      if (|cause_c) begin
        state_d = StFault;
        for (int unsigned c = 0; c < NCH; c++) begin
          if (!found && (|cause_c[c])) begin
            found   = 1'b1;
            ch_d    = CH_W'(c);
            cause_d = cause_c[c];
            addr_d  = mem_req_i[c] ? mem_addr_i[c*ADDR_W +: ADDR_W] : la_q[c];
          end
        end
      end else if (|end_c) begin
        state_d = StDone;
      end else if (|mem_req_i) begin
        state_d = StRun;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      oc_q    <= '0;
      tc_q    <= '0;
      la_q    <= '0;
      cause_q <= '0;
      ch_q    <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      oc_q    <= oc_d;
      tc_q    <= tc_d;
      la_q    <= la_d;
      cause_q <= cause_d;
      ch_q    <= ch_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o       = state_q;
  assign done_o        = (state_q == StDone);
  assign fault_o       = (state_q == StFault);
  assign fault_cause_o = cause_q;
  assign fault_ch_o    = ch_q;
  assign fault_addr_o  = addr_q;
  assign cycle_cnt_o   = cnt_q;

endmodule

// File: tb/tb_vproc_mem_monitor.sv
// Directed bench for vproc_mem_monitor; a second instance with a 4-bit counter shares
// the stimulus to exercise cycle-count saturation.
module tb_vproc_mem_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic [1:0]  req = '0;
  logic [63:0] addr = '0;
  logic [1:0]  rvalid = '0;
  logic [1:0]  err = '0;

  logic [1:0]  state, state_s;
  logic        done, done_s, fault, fault_s;
  logic [3:0]  cause, cause_s;
  logic        fch, fch_s;
  logic [31:0] faddr, faddr_s;
  logic [31:0] cnt;
  logic [3:0]  cnt_s;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  vproc_mem_monitor #(
    .NCH(2), .ADDR_W(32), .END_ADDR(32'h0), .MAX_OUT(4), .TIMEOUT(16), .CNT_W(32)
  ) u_dut (
    .clk(clk), .rst(rst), .clear_i(clear), .mem_req_i(req), .mem_addr_i(addr),
    .mem_rvalid_i(rvalid), .mem_err_i(err), .state_o(state), .done_o(done),
    .fault_o(fault), .fault_cause_o(cause), .fault_ch_o(fch), .fault_addr_o(faddr),
    .cycle_cnt_o(cnt)
  );

  vproc_mem_monitor #(
    .NCH(2), .ADDR_W(32), .END_ADDR(32'h0), .MAX_OUT(4), .TIMEOUT(16), .CNT_W(4)
  ) u_dut_sat (
    .clk(clk), .rst(rst), .clear_i(clear), .mem_req_i(req), .mem_addr_i(addr),
    .mem_rvalid_i(rvalid), .mem_err_i(err), .state_o(state_s), .done_o(done_s),
    .fault_o(fault_s), .fault_cause_o(cause_s), .fault_ch_o(fch_s), .fault_addr_o(faddr_s),
    .cycle_cnt_o(cnt_s)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present one cycle of inputs, then sample 1 time unit after the edge.
  task automatic tick(input logic [1:0] r, input logic [31:0] a0, input logic [31:0] a1,
                      input logic [1:0] rv, input logic [1:0] e);
    req    = r;
    addr   = {a1, a0};
    rvalid = rv;
    err    = e;
    @(posedge clk);
    #1;
    req    = '0;
    addr   = '0;
    rvalid = '0;
    err    = '0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_state", state, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_fault", fault, 0);
    check_eq("rst_cause", cause, 0);
    check_eq("rst_cnt", cnt, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Normal completion: 10 req/rsp pairs, one idle cycle, then the end request.
    // Counter steps on edges 1..21 after the first request edge -> 21.
    for (int i = 0; i < 10; i++) begin
      tick(2'b01, 32'h100, 32'h0, 2'b00, 2'b00);
      if (i == 0) check_eq("run_enter", state, 1);
      tick(2'b00, 32'h0, 32'h0, 2'b01, 2'b00);
    end
    tick(2'b00, 32'h0, 32'h0, 2'b00, 2'b00);
    check_eq("run_hold", state, 1);
    tick(2'b01, 32'h0, 32'h0, 2'b00, 2'b00);
    check_eq("end_state", state, 2);
    check_eq("end_done", done, 1);
    check_eq("end_fault", fault, 0);
    check_eq("end_cnt", cnt, 21);
    check_eq("end_cnt_sat", cnt_s, 15);
    tick(2'b00, 32'h0, 32'h0, 2'b11, 2'b11);
    check_eq("done_sticky", state, 2);
    check_eq("done_cnt_hold", cnt, 21);
    do_clear();
    check_eq("clr_state", state, 0);
    check_eq("clr_cnt", cnt, 0);

    // Bus error on ch1
    tick(2'b10, 32'h0, 32'h2000, 2'b00, 2'b00);
    tick(2'b00, 32'h0, 32'h0, 2'b10, 2'b10);
    check_eq("berr_fault", fault, 1);
    check_eq("berr_cause", cause, 4'b0001);
    check_eq("berr_ch", fch, 1);
    check_eq("berr_addr", faddr, 32'h2000);
    do_clear();

    // Simultaneous underflow on both channels from IDLE
    tick(2'b00, 32'h0, 32'h0, 2'b11, 2'b00);
    check_eq("udf_fault", fault, 1);
    check_eq("udf_ch", fch, 0);
    check_eq("udf_cause", cause, 4'b0010);
    do_clear();
    check_eq("udf_clr_state", state, 0);
    check_eq("udf_clr_fault", fault, 0);
    check_eq("udf_clr_cause", cause, 0);
    check_eq("udf_clr_ch", fch, 0);
    check_eq("udf_clr_addr", faddr, 0);

    // Overflow: fifth outstanding request
    for (int i = 0; i < 5; i++) begin
      tick(2'b01, 32'h40 + 32'(i), 32'h0, 2'b00, 2'b00);
      if (i == 3) check_eq("ovf_pre", fault, 0);
    end
    check_eq("ovf_fault", fault, 1);
    check_eq("ovf_cause", cause, 4'b0100);
    check_eq("ovf_addr", faddr, 32'h44);
    do_clear();

    // Req+rsp in the same cycle at the limit is legal
    for (int i = 0; i < 4; i++) tick(2'b01, 32'h50, 32'h0, 2'b00, 2'b00);
    tick(2'b01, 32'h54, 32'h0, 2'b01, 2'b00);
    check_eq("full_swap_fault", fault, 0);
    check_eq("full_swap_state", state, 1);
    do_clear();

    // Timeout: fault visible 16 edges after the request edge
    tick(2'b01, 32'h80, 32'h0, 2'b00, 2'b00);
    repeat (15) tick(2'b00, 32'h0, 32'h0, 2'b00, 2'b00);
    check_eq("tmo_pre", fault, 0);
    tick(2'b00, 32'h0, 32'h0, 2'b00, 2'b00);
    check_eq("tmo_fault", fault, 1);
    check_eq("tmo_cause", cause, 4'b1000);
    check_eq("tmo_addr", faddr, 32'h80);
    do_clear();

    // Saturation: 20 cycles of traffic; counter steps on edges 1..19
    for (int i = 0; i < 10; i++) begin
      tick(2'b01, 32'h200, 32'h0, 2'b00, 2'b00);
      tick(2'b00, 32'h0, 32'h0, 2'b01, 2'b00);
    end
    check_eq("sat_cnt_wide", cnt, 19);
    check_eq("sat_cnt", cnt_s, 15);

    // Asynchronous reset with three requests in flight
    repeat (3) tick(2'b01, 32'h210, 32'h0, 2'b00, 2'b00);
    check_eq("pre_rst_state", state, 1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_state", state, 0);
    check_eq("arst_cnt", cnt, 0);
    check_eq("arst_cnt_sat", cnt_s, 0);
    check_eq("arst_fault", fault, 0);
    check_eq("arst_addr", faddr, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick(2'b01, 32'h300, 32'h0, 2'b00, 2'b00);
    check_eq("post_rst_state", state, 1);
    tick(2'b00, 32'h0, 32'h0, 2'b01, 2'b00);
    check_eq("post_rst_fault", fault, 0);
    check_eq("post_rst_run", state, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vproc_mem_monitor.md
# vproc_mem_monitor

Parametrised multi-channel memory-bus monitor for the vproc/Ibex system. It sits beside `toplevel_498` and is wired to the request/response signals of NCH memory ports. It tracks outstanding transactions per channel and detects program end as a request to a configurable end address. It flags bus errors, response underflow/overflow and response timeouts, and keeps a saturating run-cycle count. Its registered status lets the testbench and on-chip debug logic stop on end-of-program or fault without probing internal signals.

## Interface
- NCH, 2, number of monitored memory channels (≥1)
- ADDR_W, 32, address width per channel
- END_ADDR, '0, program-end address; a request to it ends the run
- MAX_OUT, 4, maximum legal outstanding requests per channel (≥1)
- TIMEOUT, 1024, cycles a channel may have ≥1 outstanding request without a response
- CNT_W, 32, cycle-counter width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- clear_i  in  1  synchronous clear: return to IDLE and zero all counters and status
- mem_req_i  in  NCH  request accepted on channel c this cycle
- mem_addr_i  in  NCH*ADDR_W  request address; channel c occupies bits [c*ADDR_W +: ADDR_W]
- mem_rvalid_i  in  NCH  response on channel c
- mem_err_i  in  NCH  error qualifier; meaningful only when mem_rvalid_i[c]=1
- state_o  out  2  0=IDLE, 1=RUN, 2=DONE, 3=FAULT
- done_o  out  1  state_o==DONE
- fault_o  out  1  state_o==FAULT
- fault_cause_o  out  4  bit0 bus error, bit1 underflow, bit2 overflow, bit3 timeout
- fault_ch_o  out  max(1,$clog2(NCH))  channel that caused the fault
- fault_addr_o  out  ADDR_W  last request address seen on fault_ch_o
- cycle_cnt_o  out  CNT_W  cycles spent in RUN, saturating

## Operation
- **Reset (rst=0):** state IDLE. All outputs, outstanding counters, timeout counters and last-address registers are 0.
- **Per-channel outstanding count `oc[c]`:**
  - Increments on req without rvalid.
  - Decrements on rvalid without req.
  - Unchanged when both or neither are present.
  - An rvalid with err=1 is still a response and decrements.
- **Per-channel timeout counter `tc[c]`:**
  - Cleared when oc[c]==0 or when rvalid[c]=1.
  - Otherwise increments each cycle.
- **Last address:** `la[c]` captures mem_addr_i[c] on every request.
- **Per-channel fault conditions, evaluated in IDLE and RUN only:**
  - bus error: rvalid & err
  - underflow: rvalid while oc==0 (a same-cycle req does not excuse it)
  - overflow: req & ~rvalid while oc==MAX_OUT
  - timeout: tc reaches TIMEOUT-1 with oc>0 and no rvalid this cycle
- **End condition:** any channel has req with addr==END_ADDR.
- **State transitions:**
  - IDLE→RUN on the first req on any channel.
  - IDLE→DONE if that first req already targets END_ADDR.
  - RUN→DONE on the end condition.
  - IDLE/RUN→FAULT on any fault. Fault takes priority over end in the same cycle.
  - DONE and FAULT are sticky. Inputs are ignored and no counters update.
  - clear_i→IDLE from any state, with all counters and status zeroed. clear_i takes priority over every other event in its cycle.
- **Fault capture:**
  - fault_ch_o is the lowest-index faulting channel.
  - fault_cause_o holds all cause bits of that channel in that cycle.
  - fault_addr_o is that channel's address: the current mem_addr_i if req is high that cycle, else la[c].
- **cycle_cnt_o:** increments once per cycle spent in RUN, including the transition cycle into DONE/FAULT. It starts counting from the cycle after the IDLE→RUN request, saturates at 2^CNT_W−1, and holds its value in DONE/FAULT.

## Timing
- All outputs are registered. Status reflects inputs sampled at edge N and is visible after edge N (one-cycle latency).
- done_o/fault_o rise on the cycle after the offending request or response.
- Asynchronous reset takes effect immediately, including mid-transaction. Counters are discarded and no fault is raised for responses that were in flight.
- Requests and responses on different channels are fully independent. Simultaneous events on all channels are handled in the same cycle.

## Test plan
- **Normal completion:** NCH=2, END_ADDR=0.
  - ch0: req@0x100, then rvalid 1 cycle later; repeat 10×; then req@0x0.
  - Required: state RUN→DONE one cycle after the 0x0 request, done_o=1, fault_o=0, cycle_cnt_o=21.
- **Bus error:**
  - ch1: req@0x2000, then rvalid+err.
  - Required: fault_o=1, fault_cause_o=4'b0001, fault_ch_o=1, fault_addr_o=0x2000.
- **Underflow and simultaneous faults:**
  - Both channels rvalid with oc=0 in the same cycle.
  - Required: fault_ch_o=0, fault_cause_o=4'b0010.
  - A later clear_i returns to IDLE with all outputs 0.
- **Overflow and timeout:**
  - MAX_OUT=4: 5 reqs without responses → fault_cause_o=4'b0100.
  - TIMEOUT=16: 1 req with no response → fault_o high 16 cycles after the req cycle, cause=4'b1000.
  - Same-cycle req+rvalid at oc=4 → no fault.
- **Saturation and reset mid-run:**
  - CNT_W=4: run 20 cycles → cycle_cnt_o=15.
  - Assert rst mid-run with oc=3 → all outputs 0 immediately.
  - After release, the next req → RUN with no fault.
